// File: rtl/fpu_arbiter_if.sv
// Requester-side bus of the fpu arbiter: packed per-requester requests and one-hot responses.
// The arbiter uses the slave modport; the requesters (or a bench) drive the master side.
interface fpu_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_op_a;
  logic [NUM_REQ*32-1:0] req_op_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [31:0]           resp_data;
  logic [3:0]            resp_status;

  modport master (
    output req_valid, req_op_a, req_op_b,
    input  req_ready, resp_valid, resp_data, resp_status
  );

  modport slave (
    input  req_valid, req_op_a, req_op_b,
    output req_ready, resp_valid, resp_data, resp_status
  );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin sharing of one fixed-latency fpu among NUM_REQ requesters.
// One operand pair per grant; the result is returned with a one-cycle one-hot strobe.
module fpu_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int FPU_LATENCY = 8,
  parameter int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic          clock100KHz,
  input  logic          reset,
  fpu_arbiter_if.slave  req,
  output logic [31:0]   fpu_op_a,
  output logic [31:0]   fpu_op_b,
  input  logic [31:0]   fpu_data,
  input  logic [3:0]    fpu_status,
  output logic          busy
);
  localparam int CNT_W = (FPU_LATENCY > 1) ? $clog2(FPU_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   rr_ptr_reg;
  logic [IDX_W-1:0]   grant_reg;
  logic [CNT_W-1:0]   counter_reg;
  logic [31:0]        fpu_op_a_reg, fpu_op_b_reg;
  logic [31:0]        resp_data_reg;
  logic [3:0]         resp_status_reg;

  logic               found;
  logic [IDX_W-1:0]   sel;
  logic [NUM_REQ-1:0] ready_vec;
  logic [NUM_REQ-1:0] resp_vec;
  logic [31:0]        op_a_arr [NUM_REQ];
  logic [31:0]        op_b_arr [NUM_REQ];

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(32'(base)) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return sum[IDX_W-1:0];
  endfunction

  // Scan from the highest offset down so the closest requester to rr_ptr wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req.req_valid[wrap_add(rr_ptr_reg, k)]) begin
        found = 1'b1;
        sel   = wrap_add(rr_ptr_reg, k);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      // Gated by reset so no accept is offered while the block is held in reset.
      assign ready_vec[gi] = reset && (state_reg == IDLE) && found && (sel == IDX_W'(gi));
      assign resp_vec[gi]  = (state_reg == DONE) && (grant_reg == IDX_W'(gi));
      assign op_a_arr[gi]  = req.req_op_a[32*gi +: 32];
      assign op_b_arr[gi]  = req.req_op_b[32*gi +: 32];
    end
  endgenerate

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (found) state_next = WAIT;
      WAIT:    if (counter_reg == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      rr_ptr_reg      <= '0;
      grant_reg       <= '0;
      counter_reg     <= '0;
      fpu_op_a_reg    <= '0;
      fpu_op_b_reg    <= '0;
      resp_data_reg   <= '0;
      resp_status_reg <= '0;
    end else begin
      if (state_reg == IDLE && found) begin
        fpu_op_a_reg <= op_a_arr[sel];
        fpu_op_b_reg <= op_b_arr[sel];
        grant_reg    <= sel;
        rr_ptr_reg   <= wrap_add(sel, 1);
        counter_reg  <= CNT_W'(FPU_LATENCY - 1);
      end
      if (state_reg == WAIT) begin
        if (counter_reg == '0) begin
          resp_data_reg   <= fpu_data;
          resp_status_reg <= fpu_status;
        end else begin
          counter_reg <= counter_reg - CNT_W'(1);
        end
      end
    end
  end

  assign req.req_ready   = ready_vec;
  assign req.resp_valid  = resp_vec;
  assign req.resp_data   = resp_data_reg;
  assign req.resp_status = resp_status_reg;
  assign fpu_op_a        = fpu_op_a_reg;
  assign fpu_op_b        = fpu_op_b_reg;
  assign busy            = (state_reg != IDLE);
endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter with a fixed-latency fpu stub (result = a ^ b ^ salt after 8 cycles).
// Expected results per requester are hand-computed constants.
module tb_fpu_arbiter;
  localparam int NUM_REQ     = 4;
  localparam int FPU_LATENCY = 8;

  logic        clk;
  logic        reset;
  logic [31:0] fpu_op_a, fpu_op_b, fpu_data;
  logic [3:0]  fpu_status;
  logic        busy;
  int          cyc;
  int          n_total, n_pass;

  logic [31:0] a_tab [NUM_REQ];
  logic [31:0] b_tab [NUM_REQ];
  logic [31:0] exp_d [NUM_REQ];
  logic [3:0]  exp_s [NUM_REQ];

  fpu_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  fpu_arbiter #(.NUM_REQ(NUM_REQ), .FPU_LATENCY(FPU_LATENCY)) dut (
    .clock100KHz (clk),
    .reset       (reset),
    .req         (bus),
    .fpu_op_a    (fpu_op_a),
    .fpu_op_b    (fpu_op_b),
    .fpu_data    (fpu_data),
    .fpu_status  (fpu_status),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // fpu stub: output reflects operands seen FPU_LATENCY-1 edges earlier
  logic [35:0] pipe [FPU_LATENCY-1];
  always @(posedge clk) begin
    pipe[0] <= {fpu_op_a[31:28] ^ fpu_op_b[31:28] ^ 4'h1, fpu_op_a ^ fpu_op_b ^ 32'hCABE0001};
    for (int k = 1; k < FPU_LATENCY - 1; k++) pipe[k] <= pipe[k-1];
  end
  assign fpu_data   = pipe[FPU_LATENCY-2][31:0];
  assign fpu_status = pipe[FPU_LATENCY-2][35:32];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Called inside a cycle after inputs are driven; returns the accept cycle.
  task automatic wait_accept(input int exp_g, output int acc);
    int n;
    n = 0;
    #1;
    while (bus.req_ready == '0 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 40) check("accept_timeout", 64'(n), 64'd0);
    check("grant", 64'(bus.req_ready), 64'd1 << exp_g);
    acc = cyc;
    $display("accept req %0d at cycle %0d (ready=%b)", exp_g, acc, bus.req_ready);
  endtask

  // Follows one transaction from the cycle after accept to its DONE cycle.
  task automatic check_resp(input int g, input bit drop, input logic [NUM_REQ-1:0] raise_mask);
    bit bad_resp, bad_ready, bad_hold;
    bad_resp = 0; bad_ready = 0; bad_hold = 0;
    @(negedge clk);
    if (drop) bus.req_valid[g] = 1'b0;
    #1;
    check("op_a_t1", 64'(fpu_op_a), 64'(a_tab[g]));
    check("op_b_t1", 64'(fpu_op_b), 64'(b_tab[g]));
    check("busy_wait", 64'(busy), 64'd1);
    for (int c = 2; c <= FPU_LATENCY; c++) begin
      @(negedge clk);
      if (c == 2) begin
        bus.req_valid = bus.req_valid | raise_mask;
        bus.req_op_a[32*g +: 32] = ~a_tab[g];
        bus.req_op_b[32*g +: 32] = ~b_tab[g];
      end
      #1;
      if (bus.resp_valid != '0) bad_resp = 1;
      if (bus.req_ready != '0) bad_ready = 1;
      if (fpu_op_a != a_tab[g] || fpu_op_b != b_tab[g]) bad_hold = 1;
    end
    check("no_early_resp", 64'(bad_resp), 64'd0);
    check("ready_low_wait", 64'(bad_ready), 64'd0);
    check("op_hold", 64'(bad_hold), 64'd0);
    @(negedge clk);
    bus.req_op_a[32*g +: 32] = a_tab[g];
    bus.req_op_b[32*g +: 32] = b_tab[g];
    #1;
    check("resp_valid", 64'(bus.resp_valid), 64'd1 << g);
    check("resp_data", 64'(bus.resp_data), 64'(exp_d[g]));
    check("resp_status", 64'(bus.resp_status), 64'(exp_s[g]));
    check("ready_done", 64'(bus.req_ready), 64'd0);
    $display("resp req %0d at cycle %0d data=%h status=%h", g, cyc, bus.resp_data, bus.resp_status);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, prev, t0;
    bit bad;
    n_total = 0; n_pass = 0;
    a_tab = '{32'h15000000, 32'h3F800000, 32'h40400000, 32'hC0000000};
    b_tab = '{32'h15400000, 32'h40000000, 32'h40800000, 32'h3F000000};
    exp_d = '{32'hCAFE0001, 32'hB53E0001, 32'hCA7E0001, 32'h35BE0001};
    exp_s = '{4'h1, 4'h6, 4'h1, 4'hE};
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_op_a[32*i +: 32] = a_tab[i];
      bus.req_op_b[32*i +: 32] = b_tab[i];
    end
    bus.req_valid = 4'b1111;
    reset = 1'b1;
    #2 reset = 1'b0;

    // Reset with all requests pending
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_data", 64'(bus.resp_data), 64'd0);
    check("rst_resp_status", 64'(bus.resp_status), 64'd0);
    check("rst_fpu_op_a", 64'(fpu_op_a), 64'd0);
    check("rst_fpu_op_b", 64'(fpu_op_b), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Round robin with all requests held: 0,1,2,3,0 exactly 10 cycles apart
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_accept(k % NUM_REQ, acc);
      if (k > 0) check("rr_spacing", 64'(acc - prev), 64'd10);
      prev = acc;
      check_resp(k % NUM_REQ, 1'b0, '0);
    end
    bus.req_valid = '0;
    @(negedge clk); #1;
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_ready", 64'(bus.req_ready), 64'd0);
    check("idle_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("hold_resp_data", 64'(bus.resp_data), 64'(exp_d[0]));
    check("hold_fpu_op_a", 64'(fpu_op_a), 64'(a_tab[0]));

    // Single op from requester 0
    bus.req_valid = 4'b0001;
    wait_accept(0, acc);
    check_resp(0, 1'b1, '0);

    // Pointer skip: grant 1 leaves rr_ptr=2, then 4'b1001 grants 3 before 0
    bus.req_valid = 4'b0010;
    wait_accept(1, acc);
    check_resp(1, 1'b1, '0);
    bus.req_valid = 4'b1001;
    wait_accept(3, acc);
    check_resp(3, 1'b1, '0);
    wait_accept(0, acc);
    check_resp(0, 1'b1, '0);

    // Back-pressure: req1 raised during req0 WAIT, accepted right after DONE
    bus.req_valid = 4'b0001;
    wait_accept(0, t0);
    check_resp(0, 1'b1, 4'b0010);
    wait_accept(1, acc);
    check("bp_accept_cycle", 64'(acc - t0), 64'd10);
    check_resp(1, 1'b1, '0);

    // Reset in the middle of WAIT (counter==3)
    bus.req_valid = 4'b0100;
    wait_accept(2, t0);
    @(negedge clk);
    bus.req_valid[2] = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_fpu_op_a", 64'(fpu_op_a), 64'd0);
    check("midrst_fpu_op_b", 64'(fpu_op_b), 64'd0);
    check("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #1;
      if (bus.resp_valid != '0 || busy) bad = 1;
    end
    check("aborted_no_resp", 64'(bad), 64'd0);
    bus.req_valid = 4'b1111;
    wait_accept(0, acc);
    check_resp(0, 1'b1, '0);
    bus.req_valid = '0;

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
